// File: rtl/command_scheduler_if.sv
// Request/sensor/UART-TX signal bundle for command_scheduler.
// master is the scheduler's view and slave is the view of its surroundings.
`timescale 1ns/1ps
interface command_scheduler_if;
  logic       rx_done;
  logic [7:0] rx_address;
  logic [7:0] rx_command;
  logic [7:0] sens_sel;
  logic       sens_start;
  logic [7:0] sens_command;
  logic       sens_done;
  logic       sens_error;
  logic [7:0] sens_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  rx_done, rx_address, rx_command, sens_done, sens_error, sens_data, tx_busy,
    output sens_sel, sens_start, sens_command, tx_start, tx_data
  );

  modport slave (
    output rx_done, rx_address, rx_command, sens_done, sens_error, sens_data, tx_busy,
    input  sens_sel, sens_start, sens_command, tx_start, tx_data
  );
endinterface

// File: rtl/command_scheduler.sv
// Serves (address, command) requests: validates them, runs one sensor measurement under a
// timeout and returns a (code, data) byte pair over UART TX; supports continuous requests.
`timescale 1ns/1ps
module command_scheduler #(
  parameter int NUM_CH      = 32,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  command_scheduler_if.master  bus,
  output logic                 busy
);

  localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [8:0] NUM_CH_W  = 9'(NUM_CH);
  localparam logic [7:0] CMD_CONT_T = 8'h03;
  localparam logic [7:0] CMD_CONT_H = 8'h04;
  localparam logic [7:0] CMD_STOP   = 8'h05;
  localparam logic [7:0] RSP_BAD_ADDR = 8'hE0;
  localparam logic [7:0] RSP_BAD_CMD  = 8'hE1;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hE2;
  localparam logic [7:0] RSP_SENS_ERR = 8'hE3;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_SENS, S_SEND_B0, S_WAIT_B0, S_SEND_B1, S_WAIT_B1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d, cmd_q, cmd_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_addr_q, pend_addr_d, pend_cmd_q, pend_cmd_d;
  logic          cont_q, cont_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    code_q, code_d, data_q, data_d;
  logic [7:0]    sens_sel_q, sens_sel_d, sens_cmd_q, sens_cmd_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          seen_busy_q, seen_busy_d;
  logic          rx_to_pend;

  // Anything arriving while a request is in flight (or while the slot is being drained) is parked.
  assign rx_to_pend = bus.rx_done && ((state_q != S_IDLE) || pend_valid_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_cmd_d   = pend_cmd_q;
    cont_d       = cont_q;
    timer_d      = timer_q;
    code_d       = code_q;
    data_d       = data_q;
    sens_sel_d   = sens_sel_q;
    sens_cmd_d   = sens_cmd_q;
    tx_data_d    = tx_data_q;
    seen_busy_d  = seen_busy_q;
    bus.sens_start   = 1'b0;
    bus.sens_sel     = sens_sel_q;
    bus.sens_command = sens_cmd_q;
    bus.tx_start     = 1'b0;
    bus.tx_data      = tx_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          addr_d       = pend_addr_q;
          cmd_d        = pend_cmd_q;
          pend_valid_d = 1'b0;
          state_d      = S_CHECK;
        end else if (bus.rx_done) begin
          addr_d  = bus.rx_address;
          cmd_d   = bus.rx_command;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        data_d = 8'h00;
        if ({1'b0, addr_q} >= NUM_CH_W) begin
          code_d  = RSP_BAD_ADDR;
          state_d = S_SEND_B0;
        end else if (cmd_q > CMD_STOP) begin
          code_d  = RSP_BAD_CMD;
          state_d = S_SEND_B0;
        end else if (cmd_q == CMD_STOP) begin
          cont_d  = 1'b0;
          code_d  = {4'h1, cmd_q[3:0]};
          state_d = S_SEND_B0;
        end else begin
          if (cmd_q == CMD_CONT_T || cmd_q == CMD_CONT_H) cont_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.sens_start   = 1'b1;
        bus.sens_sel     = addr_q;
        bus.sens_command = cmd_q;
        sens_sel_d       = addr_q;
        sens_cmd_d       = cmd_q;
        timer_d          = '0;
        state_d          = S_WAIT_SENS;
      end
      S_WAIT_SENS: begin
        timer_d = timer_q + TW'(1);
        if (bus.sens_done) begin
          if (bus.sens_error) begin
            code_d = RSP_SENS_ERR;
            data_d = 8'h00;
            cont_d = 1'b0;
          end else begin
            code_d = {4'h1, cmd_q[3:0]};
            data_d = bus.sens_data;
          end
          state_d = S_SEND_B0;
        end else if (timer_q == TMR_LAST) begin
          code_d  = RSP_TIMEOUT;
          data_d  = 8'h00;
          cont_d  = 1'b0;
          state_d = S_SEND_B0;
        end
      end
      S_SEND_B0, S_SEND_B1: begin
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          bus.tx_data  = (state_q == S_SEND_B0) ? code_q : data_q;
          tx_data_d    = bus.tx_data;
          seen_busy_d  = 1'b0;
          state_d      = (state_q == S_SEND_B0) ? S_WAIT_B0 : S_WAIT_B1;
        end
      end
      S_WAIT_B0, S_WAIT_B1: begin
        // A byte counts as sent only after the transmitter has been seen busy and gone idle again.
        if (bus.tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          if (state_q == S_WAIT_B0) begin
            state_d = S_SEND_B1;
          end else if (cont_q && !pend_valid_q) begin
            state_d = S_ISSUE;
          end else begin
            cont_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_to_pend) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = bus.rx_address;
      pend_cmd_d   = bus.rx_command;
      if (state_q != S_IDLE && bus.rx_command == CMD_STOP && bus.rx_address == addr_q)
        cont_d = 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cmd_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_cmd_q   <= '0;
      cont_q       <= 1'b0;
      timer_q      <= '0;
      code_q       <= '0;
      data_q       <= '0;
      sens_sel_q   <= '0;
      sens_cmd_q   <= '0;
      tx_data_q    <= '0;
      seen_busy_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_cmd_q   <= pend_cmd_d;
      cont_q       <= cont_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      data_q       <= data_d;
      sens_sel_q   <= sens_sel_d;
      sens_cmd_q   <= sens_cmd_d;
      tx_data_q    <= tx_data_d;
      seen_busy_q  <= seen_busy_d;
    end
  end

endmodule

// File: tb/tb_command_scheduler.sv
// Self-checking bench for command_scheduler: sensor and UART TX models plus a scoreboard of
// expected TX bytes that the TX monitor pops and compares as each byte is launched.
`timescale 1ns/1ps
module tb_command_scheduler;
  localparam int TIMEOUT = 1000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  command_scheduler_if bus ();

  command_scheduler #(.NUM_CH(32), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_starts = 0, n_done = 0, n_tx = 0;
  int start_cyc = 0, done_cyc = 0, rx_cyc = 0;
  logic [7:0] last_sel = 8'h00, last_cmd = 8'h00;
  int  sens_delay = 10;
  bit  sens_silent = 1'b0;
  bit  sens_err = 1'b0;
  logic [7:0] sdata_q[$];
  logic [7:0] exp_q[$];
  int tx_cyc_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // UART TX model and scoreboard consumer.
  initial begin
    logic [7:0] exp_b;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset && bus.tx_start) begin
        n_tx++;
        tx_cyc_q.push_back(cyc);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_unexpected: got %02h, no byte required", bus.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.tx_data !== exp_b) begin
            fails++;
            $display("FAIL tx_byte: got %02h, required %02h", bus.tx_data, exp_b);
          end
        end
        @(posedge clock); #1;
        bus.tx_busy = 1'b1;
        repeat (3) @(posedge clock);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // Sensor model: answers each sens_start after sens_delay cycles unless silent.
  initial begin
    bus.sens_done = 1'b0;
    bus.sens_error = 1'b0;
    bus.sens_data = 8'h00;
    forever begin
      @(posedge clock); #1;
      if (reset && bus.sens_start) begin
        n_starts++;
        start_cyc = cyc;
        last_sel = bus.sens_sel;
        last_cmd = bus.sens_command;
        if (!sens_silent) begin
          repeat (sens_delay) @(posedge clock);
          #1;
          bus.sens_done = 1'b1;
          bus.sens_error = sens_err;
          bus.sens_data = (sdata_q.size() != 0) ? sdata_q.pop_front() : 8'hFF;
          done_cyc = cyc;
          n_done++;
          @(posedge clock); #1;
          bus.sens_done = 1'b0;
          bus.sens_error = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic send_rx(input logic [7:0] addr, input logic [7:0] cmd);
    @(posedge clock); #1;
    bus.rx_address = addr;
    bus.rx_command = cmd;
    bus.rx_done = 1'b1;
    rx_cyc = cyc;
    @(posedge clock); #1;
    bus.rx_done = 1'b0;
  endtask

  function automatic int get_count(input int which);
    case (which)
      0: return n_starts;
      1: return n_done;
      default: return n_tx;
    endcase
  endfunction

  // which: 0 = sensor starts, 1 = sensor results, 2 = TX bytes.
  task automatic wait_count(input string name, input int which, input int target, input int budget);
    int n = 0;
    while (get_count(which) < target && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    tests++;
    if (get_count(which) < target) begin
      fails++;
      $display("FAIL %s_wait: count %0d, required %0d", name, get_count(which), target);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_idle: busy=%b bytes_outstanding=%0d, required busy=0 and none", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset;
    bus.rx_done = 1'b0;
    bus.rx_address = 8'h00;
    bus.rx_command = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({busy, bus.sens_start, bus.tx_start, bus.sens_sel, bus.sens_command, bus.tx_data} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b ss=%b ts=%b sel=%02h cmd=%02h txd=%02h, required all 0",
               busy, bus.sens_start, bus.tx_start, bus.sens_sel, bus.sens_command, bus.tx_data);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_single_read;
    int n0 = n_starts;
    sens_delay = 100;
    sens_silent = 1'b0;
    sdata_q.push_back(8'h1A);
    tx_cyc_q.delete();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h1A);
    send_rx(8'h03, 8'h01);
    wait_done("single", 400);
    tests++;
    if (n_starts != n0 + 1 || start_cyc - rx_cyc != 2) begin
      fails++;
      $display("FAIL single_start: starts=%0d latency=%0d, required %0d and 2", n_starts - n0, start_cyc - rx_cyc, 1);
    end
    tests++;
    if (last_sel !== 8'h03 || last_cmd !== 8'h01) begin
      fails++;
      $display("FAIL single_sel: sel=%02h cmd=%02h, required 03 01", last_sel, last_cmd);
    end
    tests++;
    if (tx_cyc_q.size() < 1 || tx_cyc_q[0] - done_cyc != 1) begin
      fails++;
      $display("FAIL single_tx_latency: got %0d, required 1", (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - done_cyc : -1);
    end
  endtask

  task automatic test_bad_request;
    int n0 = n_starts;
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'h00);
    send_rx(8'h40, 8'h01);
    wait_done("bad_addr", 100);
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'h00);
    send_rx(8'h01, 8'h09);
    wait_done("bad_cmd", 100);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'h00);
    send_rx(8'h20, 8'h01);
    wait_done("addr_boundary", 100);
    tests++;
    if (n_starts != n0) begin
      fails++;
      $display("FAIL bad_no_start: got %0d starts, required 0", n_starts - n0);
    end
  endtask

  task automatic test_timeout;
    sens_silent = 1'b1;
    tx_cyc_q.delete();
    exp_q.push_back(8'hE2);
    exp_q.push_back(8'h00);
    send_rx(8'h05, 8'h02);
    wait_count("timeout_b1", 2, n_tx + 2, TIMEOUT + 200);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_busy_b1: got %b, required 1", busy);
    end
    wait_done("timeout", 100);
    tests++;
    if (tx_cyc_q.size() < 1 || tx_cyc_q[0] - start_cyc != TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout_latency: got %0d, required %0d",
               (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - start_cyc : -1, TIMEOUT + 1);
    end
    sens_silent = 1'b0;
  endtask

  task automatic test_sensor_error;
    int n0 = n_starts;
    sens_delay = 7;
    sens_err = 1'b1;
    sdata_q.push_back(8'h5A);
    exp_q.push_back(8'hE3);
    exp_q.push_back(8'h00);
    send_rx(8'h1F, 8'h04);
    wait_done("sens_err", 200);
    sens_err = 1'b0;
    tests++;
    if (n_starts != n0 + 1) begin
      fails++;
      $display("FAIL sens_err_cont_cleared: got %0d starts, required 1", n_starts - n0);
    end
  endtask

  task automatic test_continuous;
    int n0 = n_starts;
    int d0 = n_done;
    sens_delay = 5;
    sdata_q.push_back(8'h20);
    sdata_q.push_back(8'h21);
    sdata_q.push_back(8'h22);
    exp_q.push_back(8'h13); exp_q.push_back(8'h20);
    exp_q.push_back(8'h13); exp_q.push_back(8'h21);
    exp_q.push_back(8'h13); exp_q.push_back(8'h22);
    exp_q.push_back(8'h15); exp_q.push_back(8'h00);
    send_rx(8'h02, 8'h03);
    wait_count("cont_third", 1, d0 + 3, 300);
    send_rx(8'h02, 8'h05);
    wait_done("cont_stop", 300);
    tests++;
    if (n_starts != n0 + 3 || last_sel !== 8'h02 || last_cmd !== 8'h03) begin
      fails++;
      $display("FAIL cont_starts: starts=%0d sel=%02h cmd=%02h, required 3 02 03", n_starts - n0, last_sel, last_cmd);
    end
  endtask

  task automatic test_back_to_back;
    int n0 = n_starts;
    sens_delay = 50;
    sdata_q.push_back(8'h55);
    sdata_q.push_back(8'h66);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h55);
    send_rx(8'h00, 8'h01);
    wait_count("b2b_first_start", 0, n0 + 1, 20);
    send_rx(8'h00, 8'h01);
    repeat (3) @(posedge clock);
    send_rx(8'h00, 8'h02);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h66);
    wait_done("b2b", 400);
    tests++;
    if (n_starts != n0 + 2 || last_cmd !== 8'h02) begin
      fails++;
      $display("FAIL b2b_served: starts=%0d cmd=%02h, required 2 02", n_starts - n0, last_cmd);
    end
  endtask

  task automatic test_reset_mid_tx;
    sens_delay = 10;
    sdata_q.push_back(8'h77);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h77);
    send_rx(8'h04, 8'h01);
    wait_count("rst_first_byte", 2, n_tx + 1, 100);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({busy, bus.sens_start, bus.tx_start, bus.sens_sel, bus.sens_command, bus.tx_data} !== 27'd0) begin
      fails++;
      $display("FAIL midrst_outputs: busy=%b ss=%b ts=%b sel=%02h cmd=%02h txd=%02h, required all 0",
               busy, bus.sens_start, bus.tx_start, bus.sens_sel, bus.sens_command, bus.tx_data);
    end
    exp_q.delete();
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    sdata_q.push_back(8'h88);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h88);
    send_rx(8'h06, 8'h01);
    wait_done("after_rst", 200);
    tests++;
    if (last_sel !== 8'h06) begin
      fails++;
      $display("FAIL after_rst_sel: got %02h, required 06", last_sel);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_bad_request();
    test_timeout();
    test_sensor_error();
    test_continuous();
    test_back_to_back();
    test_reset_mid_tx();
    repeat (10) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
